// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI access sequencer.
// Register map, FSM state encoding and the latched host request bundle.
package hpi_pkg;

  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    GAP
  } hpi_state_t;

  typedef struct packed {
    logic        write;
    logic        mem;
    logic [1:0]  rsel;
    logic [15:0] addr;
    logic [15:0] wdata;
  } hpi_req_t;

  // Address the chip holds after one HPI_DATA access.
  function automatic logic [15:0] next_word(input logic [15:0] a);
    return a + 16'd2;
  endfunction

endpackage

// File: rtl/hpi_access_ctrl_timer.sv
// Loadable down-counter timing every HPI bus-cycle state.
// done is high while the count sits at zero.
module hpi_phase_timer
  import hpi_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic [TMR_W-1:0] count,
  output logic             done
);

  // Load on state entry, otherwise count down and stop at zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hpi_access_ctrl.sv
// Sequences host valid/ready requests into timed CY7C67200 HPI cycles.
// Optional HPI_AUTOINC_EN skips the address phase on sequential words.
module hpi_access_ctrl
  import hpi_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_mem,
  input  logic [1:0]  req_reg,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs
);

  localparam logic [TMR_W-1:0] SETUP_N  = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] STROBE_N = TMR_W'(STROBE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_N   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_N    = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] CAP_N    = TMR_W'(HOLD_CYCLES - 2);

  hpi_state_t       state;
  hpi_req_t         req_q;
  hpi_req_t         req_in;
  logic             phase_b;
  logic             start_b;
  logic             hs;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] tmr_count;
  logic             tmr_done;

`ifdef HPI_AUTOINC_EN
  logic             last_valid;
  logic [15:0]      last_addr;
`endif

  assign hs     = req_valid && req_ready;
  assign req_in = {req_write, req_mem, req_reg, req_addr, req_wdata};

  // Pick the first phase: data phase directly unless an address write is needed.
  always_comb begin
    start_b = !req_mem;
`ifdef HPI_AUTOINC_EN
    if (req_mem && last_valid && (req_addr == next_word(last_addr)))
      start_b = 1'b1;
`endif
  end

  // Reload the shared timer on every state entry.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      IDLE: if (hs) begin
        tmr_load = 1'b1;
        tmr_val  = SETUP_N;
      end
      SETUP: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = STROBE_N;
      end
      STROBE: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = HOLD_N;
      end
      HOLD: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = GAP_N;
      end
      GAP: if (tmr_done && !phase_b) begin
        tmr_load = 1'b1;
        tmr_val  = SETUP_N;
      end
      default: ;
    endcase
  end

  hpi_phase_timer u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  // Bus-cycle FSM; all HPI and host outputs are registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      req_q        <= '0;
      phase_b      <= 1'b0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      hpi_address  <= '0;
      hpi_data_out <= '0;
      hpi_r        <= 1'b1;
      hpi_w        <= 1'b1;
      hpi_cs       <= 1'b1;
`ifdef HPI_AUTOINC_EN
      last_valid   <= 1'b0;
      last_addr    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (hs) begin
            req_ready    <= 1'b0;
            req_q        <= req_in;
            phase_b      <= start_b;
            hpi_cs       <= 1'b0;
            hpi_address  <= !start_b ? HPI_REG_ADDRESS :
                            req_mem  ? HPI_REG_DATA : req_reg;
            hpi_data_out <= start_b ? req_wdata : req_addr;
            state        <= SETUP;
`ifdef HPI_AUTOINC_EN
            if (!req_mem && !req_reg[0])
              last_valid <= 1'b0;
`endif
          end
        end
        SETUP: if (tmr_done) begin
          state <= STROBE;
          if (!phase_b || req_q.write)
            hpi_w <= 1'b0;
          else
            hpi_r <= 1'b0;
        end
        STROBE: if (tmr_done) begin
          state <= HOLD;
          hpi_r <= 1'b1;
          hpi_w <= 1'b1;
        end
        HOLD: begin
          if (phase_b && !req_q.write && tmr_count == CAP_N)
            rsp_rdata <= hpi_data_in;
          if (tmr_done) begin
            state     <= GAP;
            hpi_cs    <= 1'b1;
            rsp_valid <= phase_b;
`ifdef HPI_AUTOINC_EN
            if (phase_b && req_q.mem) begin
              last_valid <= 1'b1;
              last_addr  <= req_q.addr;
            end
`endif
          end
        end
        GAP: if (tmr_done) begin
          if (!phase_b) begin
            phase_b      <= 1'b1;
            hpi_cs       <= 1'b0;
            hpi_address  <= HPI_REG_DATA;
            hpi_data_out <= req_q.wdata;
            state        <= SETUP;
          end else begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hpi_access_ctrl.md
Name: hpi_access_ctrl

Overview:
- Hardware sequencer that turns single-word host requests into timed CY7C67200 HPI bus cycles.
- Feeds the HPI I/O interface stage directly: drives its software-side address, data, rd, wr and cs inputs, and consumes its registered read data.
- Memory accesses are two phases: write the HPI_ADDRESS register, then access HPI_DATA. Register accesses (mailbox, status, data) are a single phase.
- Lets the host side issue valid/ready requests without bit-banging the HPI strobes.

Parameters:
- SETUP_CYCLES, 1: cycles CS and address are held before the strobe; minimum 1.
- STROBE_CYCLES, 4: cycles RD or WR is held low; minimum 1.
- HOLD_CYCLES, 2: cycles CS is held after the strobe; minimum 2, because read capture needs it.
- GAP_CYCLES, 1: cycles CS is high between phases and after the last phase; minimum 1.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  accepting a request
- req_write  in  1  1 = write, 0 = read
- req_mem  in  1  1 = memory access via HPI_ADDRESS/HPI_DATA; 0 = direct register access
- req_reg  in  2  register select when req_mem=0
- req_addr  in  16  CY7C67200 memory byte address when req_mem=1
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data, valid while rsp_valid=1 on reads
- hpi_address  out  2  to interface address input
- hpi_data_out  out  16  to interface write-data input
- hpi_data_in  in  16  from interface registered read data
- hpi_r  out  1  read strobe, active-low
- hpi_w  out  1  write strobe, active-low
- hpi_cs  out  1  chip select, active-low

Behaviour:
- Interface decided: one clock Clk; Reset is synchronous, active-high. Every output is registered.
- Reset values: hpi_cs=1, hpi_r=1, hpi_w=1, hpi_address=0, hpi_data_out=0, req_ready=0, rsp_valid=0, rsp_rdata=0, state=IDLE.
- Reset asserted mid-transaction: the transaction is abandoned, all strobes are high on the next cycle, and no rsp_valid is issued.
- States: IDLE, SETUP, STROBE, HOLD, GAP. A per-state down-counter loads N-1 on entry.
- IDLE: req_ready=1. Handshake is req_valid&&req_ready. On handshake, latch the request, pick the first phase and go to SETUP. req_ready=0 in every other state.
- Phase A (req_mem=1 only): address=2 (HPI_ADDRESS), write data=req_addr.
- Phase B: address=0 (HPI_DATA) if req_mem=1, else req_reg. Write data=req_wdata.
- SETUP: hpi_cs=0, hpi_address and hpi_data_out set, hpi_r=hpi_w=1.
- STROBE: hpi_cs=0. Phase A always pulls hpi_w=0. Phase B pulls hpi_w=0 if write, hpi_r=0 if read.
- HOLD: hpi_cs=0, both strobes high. Address and data stay stable from SETUP through HOLD.
- Read capture: rsp_rdata <= hpi_data_in on the 2nd HOLD cycle, i.e. two cycles after the last STROBE cycle. This accounts for the interface's output and input register stages.
- GAP: hpi_cs=1, strobes high.
  - End of GAP after phase A: go to SETUP for phase B.
  - GAP after phase B: rsp_valid=1 in its first cycle, then IDLE.
- rsp_rdata is unchanged by writes.
- Latency with defaults (handshake at cycle 0): single phase gives rsp_valid at cycle 8 and req_ready at cycle 9. Memory access gives rsp_valid at cycle 16.
- req_* inputs are ignored outside the handshake.
- No back-to-back overlap: one transaction in flight.

Optional Feature:
- Macro: HPI_AUTOINC_EN.
- Defined:
  - Track last_addr_valid and last_addr.
  - A req_mem=1 request skips phase A when last_addr_valid and req_addr==last_addr+2 (16-bit wrap; 0xFFFE+2 -> 0x0000). The chip auto-increments HPI_ADDRESS after each HPI_DATA access.
  - After each phase B of a memory access: last_addr <= address used, last_addr_valid <= 1.
  - A direct access to req_reg=0 or req_reg=2 clears last_addr_valid.
  - Reset clears last_addr_valid.
- Undefined: every memory access runs phase A.

Decomposition:
- Package hpi_pkg:
  - Register constants HPI_REG_DATA=2'd0, HPI_REG_MAILBOX=2'd1, HPI_REG_ADDRESS=2'd2, HPI_REG_STATUS=2'd3.
  - State enum hpi_state_t.
  - Request struct hpi_req_t.
- Sub-module: hpi_phase_timer. Loadable down-counter with a done flag, one instance shared by all states.

Test Plan:
- Direct read of req_reg=3 with the model returning 0x1234 two cycles after the strobe -> hpi_r low cycles 2-5, hpi_w never low, rsp_valid only at cycle 8, rsp_rdata=0x1234.
- Memory write req_addr=0x1000, wdata=0xBEEF -> phase A writes 0x1000 to addr 2 (hpi_w low cycles 2-5); phase B writes 0xBEEF to addr 0 (cycles 10-13); rsp_valid at 16.
- Memory read 0x0500 returning 0xCAFE -> addr-2 write then addr-0 read; rsp_rdata=0xCAFE at cycle 16; hpi_data_out stable during every SETUP..HOLD.
- Reset asserted at cycle 4 of a write -> next cycle hpi_cs=hpi_r=hpi_w=1, req_ready=0, no rsp_valid; the following request completes normally.
- req_valid held high continuously -> exactly one request accepted per IDLE visit; req_ready=0 from cycle 1 to rsp_valid.
- HPI_AUTOINC_EN defined, memory reads 0x1000 then 0x1002 -> second has no addr-2 phase, rsp_valid 8 cycles after accept; then read 0x2000 runs phase A.
